// File: rtl/ro_sense_pkg.sv
// Shared types and default sizing for the ring-oscillator sense readers.
package ro_sense_pkg;

    localparam int RO_SENSE_CNT_W       = 16;
    localparam int RO_SENSE_WIN_W       = 16;
    localparam int RO_SENSE_SYNC_STAGES = 2;

    // Measurement sequencer states, also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } ro_sense_state_e;

endpackage

// File: rtl/ro_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a rising-edge
// detector on the synchronized value. STAGES must be at least 2.
// The edge history flop runs every cycle, so a level that was already high
// before anyone looks at `rise` never produces a pulse.
module ro_sync_edge
    import ro_sense_pkg::*;
#(
    parameter int STAGES = RO_SENSE_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the async input through the synchronizer and keep one cycle of history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign sync_out = r_sync[STAGES-1];
    assign rise     = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/ro_sense_counter.sv
// Counts rising edges of an asynchronous ring-oscillator output over a
// programmable window of clock cycles and hands the saturating count to the
// consumer through a valid/ready result port.
//
// Result handshake: result_valid is high in DONE and stays high, with
// result_count/result_ovf frozen, until a cycle where result_ready is also
// high; that cycle completes the transfer and the block is IDLE the next cycle.
//
// Only ROs slower than clock/2 are resolved; faster ones alias.
module ro_sense_counter
    import ro_sense_pkg::*;
#(
    parameter int CNT_W       = RO_SENSE_CNT_W,
    parameter int WIN_W       = RO_SENSE_WIN_W,
    parameter int SYNC_STAGES = RO_SENSE_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ro_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic             abort,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_count,
    output logic             result_ovf,
    output ro_sense_state_e  o_dbg_state,
    output logic             o_dbg_ro_sync
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    ro_sense_state_e  r_state;
    ro_sense_state_e  w_next;
    logic [WIN_W-1:0] r_win_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] r_res_count;
    logic             r_res_ovf;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_rise;
    logic             w_sync;

    ro_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clock    (clock),
        .reset    (reset),
        .async_in (ro_in),
        .sync_out (w_sync),
        .rise     (w_rise)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort only matters while a measurement is in flight.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = ARM;
            end
            ARM: begin
                if (abort)                 w_next = IDLE;
                else if (r_win_rem == '0)  w_next = DONE;
                else                       w_next = MEASURE;
            end
            MEASURE: begin
                if (abort)                     w_next = IDLE;
                else if (r_win_rem == WIN_ONE) w_next = DONE;
            end
            DONE: begin
                if (result_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Saturating edge count for this cycle; an edge at full scale flags overflow.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (w_rise) begin
            if (r_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
            else                  w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Window/count datapath; the published result only changes on start or at window end,
    // so an aborted run leaves nothing behind but the cleared result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_win_rem   <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_res_count <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_win_rem   <= window_len;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_res_count <= '0;
                        r_res_ovf   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!abort) begin
                        r_win_rem <= r_win_rem - WIN_ONE;
                        r_cnt     <= w_cnt_nxt;
                        r_ovf     <= w_ovf_nxt;
                        if (r_win_rem == WIN_ONE) begin
                            r_res_count <= w_cnt_nxt;
                            r_res_ovf   <= w_ovf_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (r_state == ARM) || (r_state == MEASURE);
    assign result_valid  = (r_state == DONE);
    assign result_count  = r_res_count;
    assign result_ovf    = r_res_ovf;
    assign o_dbg_state   = r_state;
    assign o_dbg_ro_sync = w_sync;

endmodule

// File: tb/tb_ro_sense_counter.sv
// Bench for ro_sense_counter: two instances (16-bit and 4-bit counters)
// share all inputs so the saturation case runs alongside the normal one.
module tb_ro_sense_counter;
    import ro_sense_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset;
    logic        ro_in;
    logic        start;
    logic [15:0] window_len;
    logic        abort;
    logic        result_ready;

    logic            busy16, valid16, ovf16, sync16;
    logic [15:0]     count16;
    ro_sense_state_e st16;
    logic            busy4, valid4, ovf4, sync4;
    logic [3:0]      count4;
    ro_sense_state_e st4;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ro_mode  = 0;     // 0 low, 1 high, 2 square wave period 4 clocks
    logic [1:0] ro_ph = '0;

    logic [21:0] exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    ro_sense_counter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) u_dut16 (
        .clock(clock), .reset(reset), .ro_in(ro_in), .start(start),
        .window_len(window_len), .abort(abort), .busy(busy16),
        .result_valid(valid16), .result_ready(result_ready),
        .result_count(count16), .result_ovf(ovf16),
        .o_dbg_state(st16), .o_dbg_ro_sync(sync16)
    );

    ro_sense_counter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) u_dut4 (
        .clock(clock), .reset(reset), .ro_in(ro_in), .start(start),
        .window_len(window_len), .abort(abort), .busy(busy4),
        .result_valid(valid4), .result_ready(result_ready),
        .result_count(count4), .result_ovf(ovf4),
        .o_dbg_state(st4), .o_dbg_ro_sync(sync4)
    );

    // RO stimulus, changed mid-cycle so it never coincides with a clock edge.
    initial begin
        ro_in = 1'b0;
        forever begin
            @(posedge clock);
            #3;
            case (ro_mode)
                0:       ro_in = 1'b0;
                1:       ro_in = 1'b1;
                default: begin
                    ro_ph = ro_ph + 2'd1;
                    ro_in = ro_ph[1];
                end
            endcase
        end
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] pack_res(input logic [15:0] c16, input logic o16,
                                             input logic [3:0] c4, input logic o4);
        return {o4, c4, o16, c16};
    endfunction

    function automatic logic [21:0] observed();
        return {ovf4, count4, ovf16, count16};
    endfunction

    // Expected results for a square-wave window of n cycles (n multiple of 4).
    function automatic logic [21:0] sq_expect(input int n);
        int k;
        k = n / 4;
        return pack_res(16'(k), 1'b0, (k > 15) ? 4'd15 : 4'(k), (k > 15));
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},  {30'd0, busy16, busy4}, 32'd0);
        check_eq({tag, "_valid"}, {30'd0, valid16, valid4}, 32'd0);
        check_eq({tag, "_state"}, {28'd0, st16, st4}, {28'd0, IDLE, IDLE});
    endtask

    // Start one measurement, check latency and result, optionally hold DONE
    // for `hold` cycles (pulsing start/abort), then acknowledge.
    task automatic run_meas(input string tag, input int n, input int hold, input logic [21:0] exp);
        int          lat;
        logic [21:0] got;
        logic [21:0] want;
        exp_q.push_back(exp);
        start      = 1'b1;
        window_len = 16'(n);
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_arm"}, {30'd0, busy16, busy4}, 32'd3);
        lat = 1;
        while (!valid16 && lat < n + 50) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(n + 2));
        want = exp_q.pop_front();
        got  = observed();
        check_eq({tag, "_result"}, {10'd0, got}, {10'd0, want});
        for (int i = 0; i < hold; i++) begin
            start = ~i[0];
            abort = i[0];
            tick();
            check_eq({tag, "_hold_result"}, {10'd0, observed()}, {10'd0, want});
            check_eq({tag, "_hold_valid"}, {30'd0, valid16, valid4}, 32'd3);
        end
        start        = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_idle_outputs({tag, "_ack"});
        check_eq({tag, "_idle_keeps"}, {10'd0, observed()}, {10'd0, want});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int vcount;
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b0;
        window_len   = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("reset");
        check_eq("reset_result", {10'd0, observed()}, 32'd0);

        // Square wave, 100-cycle window: 25 edges, 4-bit copy saturates.
        ro_mode = 2;
        repeat (8) tick();
        run_meas("sq100", 100, 0, pack_res(16'd25, 1'b0, 4'd15, 1'b1));

        // Zero-length window while the RO toggles.
        repeat (3) tick();
        run_meas("win0", 0, 0, pack_res(16'd0, 1'b0, 4'd0, 1'b0));

        // RO held high across start: the primed history must not see an edge.
        ro_mode = 1;
        repeat (6) tick();
        run_meas("high10", 10, 0, pack_res(16'd0, 1'b0, 4'd0, 1'b0));

        // Result held in DONE for 20 cycles while start/abort pulse and the RO toggles.
        ro_mode = 2;
        repeat (8) tick();
        run_meas("hold20", 20, 20, pack_res(16'd5, 1'b0, 4'd5, 1'b0));

        // Abort in the 50th MEASURE cycle of a 100-cycle window.
        start      = 1'b1;
        window_len = 16'd100;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check_eq("abort_pre_state", {28'd0, st16, st4}, {28'd0, MEASURE, MEASURE});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort");
        vcount = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (valid16 || valid4) vcount++;
        end
        check_eq("abort_no_valid", 32'(vcount), 32'd0);
        run_meas("after_abort", 100, 0, pack_res(16'd25, 1'b0, 4'd15, 1'b1));

        // Random window lengths (multiples of 4 so the edge count is exact).
        for (int r = 0; r < 3; r++) begin
            n = 4 * $urandom_range(1, 25);
            repeat (2) tick();
            run_meas("rand", n, $urandom_range(0, 3), sq_expect(n));
        end

        // Reset in the middle of MEASURE: outputs drop without a clock edge.
        start      = 1'b1;
        window_len = 16'd100;
        tick();
        start = 1'b0;
        repeat (30) tick();
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        check_eq("midreset_result", {10'd0, observed()}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check_idle_outputs("post_reset");
        run_meas("post_reset_meas", 100, 0, pack_res(16'd25, 1'b0, 4'd15, 1'b1));

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
